// File: rtl/pc_fetch.sv
// Instruction-fetch front end: owns the PC, addresses the instruction ROM and
// registers the returned word into the IF/ID pipeline register.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [15:0] inst_addr,
  input  logic [31:0] inst,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [31:0] if_inst,
  output logic [31:0] fetch_cnt
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } fetch_state_e;

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic         w_advance;
  logic [31:0]  w_pc_plus4;

  logic [31:0]  r_pc;
  logic [31:0]  r_if_pc;
  logic [31:0]  r_if_pc4;
  logic [31:0]  r_if_inst;
  logic [31:0]  r_fetch_cnt;

  // Wraps modulo 2^32, so 32'hFFFF_FFFC advances to zero.
  assign w_pc_plus4 = r_pc + 32'd4;

  // Redirect outranks stall; a redirected edge never delivers an instruction.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    if (redirect_valid) begin
      w_state_nxt = S_EMPTY;
    end else if (!stall) begin
      w_state_nxt = S_FULL;
      w_advance   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values from
    // before this edge, independent of statement order.
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_pc        <= {RESET_PC[31:2], 2'b00};
      r_if_pc     <= '0;
      r_if_pc4    <= '0;
      r_if_inst   <= '0;
      r_fetch_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_valid) begin
        r_pc <= {redirect_pc[31:2], 2'b00};
      end else if (w_advance) begin
        r_pc        <= w_pc_plus4;
        r_if_pc     <= r_pc;
        r_if_pc4    <= w_pc_plus4;
        r_if_inst   <= inst;
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
    end
  end

  // ROM address comes straight from the PC register, never from stall/redirect.
  assign inst_addr = r_pc[17:2];
  assign if_valid  = (r_state == S_FULL);
  assign if_pc     = r_if_pc;
  assign if_pc4    = r_if_pc4;
  assign if_inst   = r_if_inst;
  assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios with constant expectations, then a
// randomized run against a behavioural model of the fetch rules.
module tb_pc_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [15:0] inst_addr;
  logic [31:0] inst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_inst;
  logic [31:0] fetch_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: the architectural PC and what IF/ID should hold.
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_if_pc;
  logic [31:0] m_if_pc4;
  logic [31:0] m_if_inst;
  logic [31:0] m_cnt;

  pc_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_addr      (inst_addr),
    .inst           (inst),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_pc4         (if_pc4),
    .if_inst        (if_inst),
    .fetch_cnt      (fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [15:0] a);
    return 32'h1000_0000 + {16'h0000, a};
  endfunction

  assign inst = rom(inst_addr);

  // Advance the model by the edge's priority rules, then let the DUT take the
  // same edge and settle before anything is sampled.
  task automatic tick();
    logic [31:0] pc_now;
    pc_now = m_pc;
    if (!rst_n) begin
      m_pc = RESET_PC; m_valid = 1'b0;
      m_if_pc = '0; m_if_pc4 = '0; m_if_inst = '0; m_cnt = '0;
    end else if (redirect_valid) begin
      m_pc = redirect_pc & 32'hFFFF_FFFC;
      m_valid = 1'b0;
    end else if (!stall) begin
      m_if_pc   = pc_now;
      m_if_pc4  = pc_now + 32'd4;
      m_if_inst = rom(pc_now[17:2]);
      m_valid   = 1'b1;
      m_cnt     = m_cnt + 32'd1;
      m_pc      = pc_now + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    tick();
    tick();
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    n_cmp++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL reset_if_pc: got %h want 0", if_pc); end
    n_cmp++; if (if_pc4 !== 32'h0) begin n_err++; $display("FAIL reset_if_pc4: got %h want 0", if_pc4); end
    n_cmp++; if (if_inst !== 32'h0) begin n_err++; $display("FAIL reset_if_inst: got %h want 0", if_inst); end
    n_cmp++; if (fetch_cnt !== 32'h0) begin n_err++; $display("FAIL reset_cnt: got %h want 0", fetch_cnt); end
    n_cmp++; if (inst_addr !== RESET_PC[17:2]) begin n_err++; $display("FAIL reset_addr: got %h want %h", inst_addr, RESET_PC[17:2]); end
  endtask

  task automatic test_sequential(input int edges);
    rst_n = 1'b1;
    for (int k = 0; k < edges; k++) begin
      tick();
      n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid[%0d]: got %b want 1", k, if_valid); end
      n_cmp++; if (if_pc !== 32'(4 * k)) begin n_err++; $display("FAIL seq_if_pc[%0d]: got %h want %h", k, if_pc, 32'(4 * k)); end
      n_cmp++; if (if_pc4 !== 32'(4 * k + 4)) begin n_err++; $display("FAIL seq_if_pc4[%0d]: got %h want %h", k, if_pc4, 32'(4 * k + 4)); end
      n_cmp++; if (if_inst !== 32'h1000_0000 + 32'(k)) begin n_err++; $display("FAIL seq_if_inst[%0d]: got %h want %h", k, if_inst, 32'h1000_0000 + 32'(k)); end
      n_cmp++; if (fetch_cnt !== 32'(k + 1)) begin n_err++; $display("FAIL seq_cnt[%0d]: got %0d want %0d", k, fetch_cnt, k + 1); end
    end
  endtask

  // Expects IF/ID to hold pc 8 (third instruction) on entry.
  task automatic test_stall();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (if_pc !== 32'h8) begin n_err++; $display("FAIL stall_if_pc[%0d]: got %h want 8", k, if_pc); end
      n_cmp++; if (if_inst !== 32'h1000_0002) begin n_err++; $display("FAIL stall_if_inst[%0d]: got %h want 10000002", k, if_inst); end
      n_cmp++; if (fetch_cnt !== 32'd3) begin n_err++; $display("FAIL stall_cnt[%0d]: got %0d want 3", k, fetch_cnt); end
      n_cmp++; if (inst_addr !== 16'h0003) begin n_err++; $display("FAIL stall_addr[%0d]: got %h want 0003", k, inst_addr); end
      n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 1", k, if_valid); end
    end
    stall = 1'b0;
    tick();
    n_cmp++; if (if_pc !== 32'hC) begin n_err++; $display("FAIL stall_release_pc: got %h want c", if_pc); end
    n_cmp++; if (fetch_cnt !== 32'd4) begin n_err++; $display("FAIL stall_release_cnt: got %0d want 4", fetch_cnt); end
  endtask

  // Entered with pc = 0x10 and fetch_cnt = 4.
  task automatic test_redirect();
    n_cmp++; if (inst_addr !== 16'h0004) begin n_err++; $display("FAIL redir_pre_addr: got %h want 0004", inst_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL redir_bubble_valid: got %b want 0", if_valid); end
    n_cmp++; if (inst_addr !== 16'h0010) begin n_err++; $display("FAIL redir_addr: got %h want 0010", inst_addr); end
    n_cmp++; if (fetch_cnt !== 32'd4) begin n_err++; $display("FAIL redir_bubble_cnt: got %0d want 4", fetch_cnt); end
    n_cmp++; if (if_pc !== 32'hC) begin n_err++; $display("FAIL redir_bubble_hold_pc: got %h want c", if_pc); end
    tick();
    n_cmp++; if (if_pc !== 32'h40) begin n_err++; $display("FAIL redir_target_pc: got %h want 40", if_pc); end
    n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL redir_target_valid: got %b want 1", if_valid); end
    n_cmp++; if (if_inst !== 32'h1000_0010) begin n_err++; $display("FAIL redir_target_inst: got %h want 10000010", if_inst); end
    n_cmp++; if (fetch_cnt !== 32'd5) begin n_err++; $display("FAIL redir_target_cnt: got %0d want 5", fetch_cnt); end
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rs_valid: got %b want 0", if_valid); end
    n_cmp++; if (inst_addr !== 16'h0080) begin n_err++; $display("FAIL rs_addr: got %h want 0080", inst_addr); end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rs_hold_valid[%0d]: got %b want 0", k, if_valid); end
      n_cmp++; if (inst_addr !== 16'h0080) begin n_err++; $display("FAIL rs_hold_addr[%0d]: got %h want 0080", k, inst_addr); end
    end
    stall = 1'b0;
    tick();
    n_cmp++; if (if_pc !== 32'h200) begin n_err++; $display("FAIL rs_release_pc: got %h want 200", if_pc); end
    n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL rs_release_valid: got %b want 1", if_valid); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (inst_addr !== 16'hFFFF) begin n_err++; $display("FAIL wrap_addr: got %h want ffff", inst_addr); end
    tick();
    n_cmp++; if (if_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_if_pc: got %h want fffffffc", if_pc); end
    n_cmp++; if (if_pc4 !== 32'h0) begin n_err++; $display("FAIL wrap_if_pc4: got %h want 0", if_pc4); end
    n_cmp++; if (if_inst !== 32'h1000_FFFF) begin n_err++; $display("FAIL wrap_if_inst: got %h want 1000ffff", if_inst); end
    n_cmp++; if (inst_addr !== 16'h0000) begin n_err++; $display("FAIL wrap_next_addr: got %h want 0000", inst_addr); end
    tick();
    n_cmp++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL wrap_next_pc: got %h want 0", if_pc); end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0; stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_1234;
    tick();
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", if_valid); end
    n_cmp++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL rmid_if_pc: got %h want 0", if_pc); end
    n_cmp++; if (if_pc4 !== 32'h0) begin n_err++; $display("FAIL rmid_if_pc4: got %h want 0", if_pc4); end
    n_cmp++; if (if_inst !== 32'h0) begin n_err++; $display("FAIL rmid_if_inst: got %h want 0", if_inst); end
    n_cmp++; if (fetch_cnt !== 32'h0) begin n_err++; $display("FAIL rmid_cnt: got %h want 0", fetch_cnt); end
    n_cmp++; if (inst_addr !== RESET_PC[17:2]) begin n_err++; $display("FAIL rmid_addr: got %h want %h", inst_addr, RESET_PC[17:2]); end
    rst_n = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    tick();
    n_cmp++; if (if_pc !== RESET_PC) begin n_err++; $display("FAIL rmid_resume_pc: got %h want %h", if_pc, RESET_PC); end
    n_cmp++; if (fetch_cnt !== 32'd1) begin n_err++; $display("FAIL rmid_resume_cnt: got %0d want 1", fetch_cnt); end
  endtask

  task automatic test_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      rst_n          = ($urandom_range(63) != 0);
      stall          = ($urandom_range(3) == 0);
      redirect_valid = ($urandom_range(7) == 0);
      redirect_pc    = $urandom;
      tick();
      n_cmp++; if (if_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, if_valid, m_valid); end
      n_cmp++; if (if_pc !== m_if_pc) begin n_err++; $display("FAIL rnd_if_pc[%0d]: got %h want %h", c, if_pc, m_if_pc); end
      n_cmp++; if (if_pc4 !== m_if_pc4) begin n_err++; $display("FAIL rnd_if_pc4[%0d]: got %h want %h", c, if_pc4, m_if_pc4); end
      n_cmp++; if (if_inst !== m_if_inst) begin n_err++; $display("FAIL rnd_if_inst[%0d]: got %h want %h", c, if_inst, m_if_inst); end
      n_cmp++; if (fetch_cnt !== m_cnt) begin n_err++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", c, fetch_cnt, m_cnt); end
      n_cmp++; if (inst_addr !== m_pc[17:2]) begin n_err++; $display("FAIL rnd_addr[%0d]: got %h want %h", c, inst_addr, m_pc[17:2]); end
    end
    rst_n = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    m_pc = RESET_PC; m_valid = 1'b0;
    m_if_pc = '0; m_if_pc4 = '0; m_if_inst = '0; m_cnt = '0;
    test_reset();
    test_sequential(4);
    test_reset();
    test_sequential(3);
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_reset_mid();
    test_random(400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch front end: owns the program counter, drives the word address into the combinational instruction ROM and registers the returned instruction into the IF/ID pipeline register for decode. Handles sequential PC advance, pipeline stall (hold) and control-flow redirect (branch/jump/exception) with squash of the wrong-path fetch. Sits between the core's hazard/branch logic and the decode stage, with the instruction ROM hanging off its address output.

## Interface
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset; bits [1:0] must be 0
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- stall  in  1  hold PC and IF/ID register this cycle
- redirect_valid  in  1  load redirect_pc into PC and squash the current fetch
- redirect_pc  in  32  redirect target byte address; bits [1:0] ignored (treated as 0)
- inst_addr  out  16  word address to instruction ROM, = pc[17:2], combinational
- inst  in  32  instruction word from ROM, combinational response to inst_addr
- if_valid  out  1  IF/ID register holds a live instruction
- if_pc  out  32  byte address of instruction in IF/ID
- if_pc4  out  32  if_pc + 4 (link/branch base for decode)
- if_inst  out  32  instruction word in IF/ID
- fetch_cnt  out  32  count of instructions delivered to IF/ID with if_valid=1

## Operation
- Internal PC register, 32 bits, word aligned; pc[1:0] always 0.
- Next-state priority, evaluated each rising edge:
  1. rst_n=0: pc<=RESET_PC; if_valid<=0; if_pc, if_pc4, if_inst, fetch_cnt <=0.
  2. redirect_valid=1 (regardless of stall): pc<={redirect_pc[31:2],2'b00}; if_valid<=0; if_pc/if_pc4/if_inst hold; fetch_cnt holds.
  3. stall=1: pc, if_valid, if_pc, if_pc4, if_inst, fetch_cnt all hold.
  4. otherwise: if_pc<=pc; if_pc4<=pc+4; if_inst<=inst; if_valid<=1; fetch_cnt<=fetch_cnt+1; pc<=pc+4.
- Arithmetic: pc+4 modulo 2^32; 32'hFFFF_FFFC advances to 32'h0000_0000. fetch_cnt wraps 32'hFFFF_FFFF -> 0.
- inst_addr uses pc[17:2] only; PCs above 18 bits alias into the 64K-word ROM (no fault).
- Implicit two-state fetch control: EMPTY (if_valid=0, after reset or redirect) and FULL (if_valid=1). EMPTY->FULL on any non-stalled, non-redirected cycle; FULL->EMPTY only on redirect or reset; stall keeps current state.
- Redirect squashes exactly one fetch slot: the instruction addressed during the redirect cycle is never delivered.
- No combinational path from redirect_valid or stall to inst_addr; inst_addr depends only on the PC register.

## Timing
- Reset values (after a clock edge with rst_n=0): pc=RESET_PC, inst_addr=RESET_PC[17:2], if_valid=0, if_pc=0, if_pc4=0, if_inst=0, fetch_cnt=0.
- First delivery: rst_n released before edge E0 -> at E0 the instruction at RESET_PC is latched; if_valid=1, if_pc=RESET_PC visible after E0.
- Fetch latency: PC value P present during cycle n -> if_inst=mem[P[17:2]], if_pc=P visible in cycle n+1. Throughput one instruction per cycle without stall.
- Redirect latency: redirect_valid sampled at edge E -> after E, pc=target, if_valid=0; target instruction visible in IF/ID after E+1 (if not stalled). Redirect penalty: 1 bubble.
- Back-to-back redirects: each one overrides the previous; if_valid stays 0 until the first non-redirected, non-stalled edge.
- Redirect and stall in the same cycle: redirect wins; stall is ignored for that edge.
- Reset asserted mid-stream overrides redirect and stall; no state survives.

## Test plan
- Reset/sequential: RESET_PC=0, ROM word k = 32'h1000_0000+k, no stall/redirect for 4 edges -> if_pc 0,4,8,C; if_inst 1000_0000..1000_0003; if_pc4 = if_pc+4; fetch_cnt 1..4; if_valid 0 before first edge after reset then 1.
- Stall: stall=1 for 3 cycles while if_pc=8 -> if_pc, if_inst, fetch_cnt, inst_addr frozen 3 cycles; on release next if_pc=C.
- Redirect: at pc=10 assert redirect_valid with redirect_pc=32'h0000_0043 for one cycle -> next edge if_valid=0, inst_addr=0x10; following edge if_pc=0x40, if_valid=1, fetch_cnt unchanged across bubble.
- Redirect+stall simultaneous: stall=1, redirect_valid=1, redirect_pc=0x200 -> pc=0x200, if_valid=0; stall held 2 more cycles keeps if_valid=0; on release if_pc=0x200.
- Wrap: redirect to 32'hFFFF_FFFC -> delivered if_pc=FFFF_FFFC with if_pc4=0, inst_addr=16'hFFFF; next if_pc=0, inst_addr=0.
- Reset mid-operation: rst_n=0 for one edge while redirect_valid=1 and stall=1 -> all outputs at reset values, pc=RESET_PC; normal fetch resumes from RESET_PC.
